// File: rtl/weight_preload.sv
// Weight preload path: packs AXI-Stream beats into wide weight words and
// queues them in a small first-word-fall-through FIFO for the MAC array.
module weight_preload #(
  parameter int unsigned MAC_NUM                 = 256,
  parameter int unsigned AXIS_DATA_WIDTH         = 64,
  parameter int unsigned AXIS_PRELOAD_FIFO_DEPTH = 4,
  parameter int unsigned bit_num                 = $clog2(AXIS_PRELOAD_FIFO_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic                            transfer_start,
  input  logic                            axis_fifo_read,
  output logic [5*MAC_NUM-1:0]            weight_from_preload,
  output logic [bit_num:0]                axis_fifo_cnt,
  output logic                            wait_weight_preload,
  output logic [12:0]                     preload_word_cnt,
  output logic                            frame_err
);

  localparam int unsigned WW    = 5 * MAC_NUM;
  localparam int unsigned ADW   = AXIS_DATA_WIDTH;
  localparam int unsigned BEATS = WW / ADW;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH = AXIS_PRELOAD_FIFO_DEPTH;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = bit_num + 1;
  localparam int unsigned WCW   = 13;

  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           frame_err_q, frame_err_d;
  logic           wait_q, wait_d;
  logic [WW-1:0]  pack_q, pack_d;
  logic [WW-1:0]  push_word;
  logic [WW-1:0]  mem [DEPTH];

  logic last_beat, full, accept, push, pop, short_pkt;

  // Handshake, FIFO bookkeeping and packing control
  always_comb begin
    last_beat     = (beat_cnt_q == BCW'(BEATS - 1));
    full          = (cnt_q == CW'(DEPTH));
    s_axis_tready = !rst && !transfer_start && !(last_beat && full);
    accept        = s_axis_tvalid && s_axis_tready;
    push          = accept && last_beat;
    short_pkt     = accept && s_axis_tlast && !last_beat;
    pop           = axis_fifo_read && (cnt_q != '0) && !transfer_start;

    beat_cnt_d  = beat_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    word_cnt_d  = word_cnt_q;
    frame_err_d = frame_err_q;
    pack_d      = pack_q;
    push_word   = pack_q;
    push_word[(BEATS-1)*ADW +: ADW] = s_axis_tdata;

    if (accept) begin
      if (last_beat || short_pkt) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + BCW'(1);
        pack_d[int'(beat_cnt_q)*ADW +: ADW] = s_axis_tdata;
      end
    end
    if (short_pkt) frame_err_d = 1'b1;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (word_cnt_q != {WCW{1'b1}}) word_cnt_d = word_cnt_q + WCW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Flush overrides everything, including a same-cycle pop
    if (transfer_start) begin
      beat_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      word_cnt_d  = '0;
      frame_err_d = 1'b0;
    end
    wait_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      word_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      frame_err_q <= frame_err_d;
      wait_q      <= wait_d;
    end
  end

  // Data storage carries no reset; validity is tracked by the counters
  always_ff @(posedge clk) begin
    pack_q <= pack_d;
    if (push) mem[wr_ptr_q] <= push_word;
  end

  assign weight_from_preload = mem[rd_ptr_q];
  assign axis_fifo_cnt       = cnt_q;
  assign wait_weight_preload = wait_q;
  assign preload_word_cnt    = word_cnt_q;
  assign frame_err           = frame_err_q;

endmodule

// File: tb/tb_weight_preload.sv
// Directed self-checking bench for weight_preload at default parameters.
module tb_weight_preload;

  localparam int unsigned WW = 1280;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          transfer_start;
  logic          axis_fifo_read;
  logic [WW-1:0] weight_from_preload;
  logic [2:0]    axis_fifo_cnt;
  logic          wait_weight_preload;
  logic [12:0]   preload_word_cnt;
  logic          frame_err;

  int checks   = 0;
  int failures = 0;

  weight_preload dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .transfer_start      (transfer_start),
    .axis_fifo_read      (axis_fifo_read),
    .weight_from_preload (weight_from_preload),
    .axis_fifo_cnt       (axis_fifo_cnt),
    .wait_weight_preload (wait_weight_preload),
    .preload_word_cnt    (preload_word_cnt),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] head_beat(input int k);
    return weight_from_preload[k*64 +: 64];
  endfunction

  // One beat: wait (bounded) for tready, then let one edge accept it
  task automatic send_beat(input logic [63:0] d, input logic l);
    int guard = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      failures++;
      $display("FAIL tready_timeout observed=0 expected=1");
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_word(input int w, input logic with_last);
    for (int k = 0; k < 20; k++)
      send_beat(64'(w * 256 + k), with_last && (k == 19));
  endtask

  task automatic flush();
    transfer_start = 1'b1;
    #1;
    chk("tready_during_flush", 64'(s_axis_tready), 64'd0);
    tick();
    transfer_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    transfer_start = 1'b0; axis_fifo_read = 1'b0;
    tick();
    tick();
    chk("reset_tready", 64'(s_axis_tready), 64'd0);
    chk("reset_cnt", 64'(axis_fifo_cnt), 64'd0);
    chk("reset_wait", 64'(wait_weight_preload), 64'd0);
    chk("reset_wordcnt", 64'(preload_word_cnt), 64'd0);
    chk("reset_ferr", 64'(frame_err), 64'd0);
    rst = 1'b0;
    tick();

    // Basic packing of beats 1..20
    for (int n = 1; n <= 20; n++) send_beat(64'(n), 1'b0);
    chk("w0_cnt", 64'(axis_fifo_cnt), 64'd1);
    chk("w0_wait", 64'(wait_weight_preload), 64'd1);
    chk("w0_beat0", head_beat(0), 64'h1);
    chk("w0_beat1", head_beat(1), 64'h2);
    chk("w0_beat19", head_beat(19), 64'h14);
    chk("w0_wordcnt", 64'(preload_word_cnt), 64'd1);
    flush();
    chk("flush_cnt", 64'(axis_fifo_cnt), 64'd0);
    chk("flush_wordcnt", 64'(preload_word_cnt), 64'd0);

    // Back-pressure on a full FIFO
    for (int n = 1; n <= 99; n++) send_beat(64'(n), 1'b0);
    s_axis_tdata = 64'd100; s_axis_tvalid = 1'b1;
    #1;
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    chk("full_cnt", 64'(axis_fifo_cnt), 64'd4);
    axis_fifo_read = 1'b1;
    tick();
    axis_fifo_read = 1'b0;
    #1;
    chk("pop_full_cnt", 64'(axis_fifo_cnt), 64'd3);
    chk("pop_full_head", head_beat(0), 64'd21);
    chk("pop_full_tready", 64'(s_axis_tready), 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    chk("refill_cnt", 64'(axis_fifo_cnt), 64'd4);
    chk("refill_wordcnt", 64'(preload_word_cnt), 64'd5);
    flush();

    // Simultaneous push and pop
    send_word(1, 1'b0);
    send_word(2, 1'b0);
    chk("two_cnt", 64'(axis_fifo_cnt), 64'd2);
    for (int k = 0; k < 19; k++) send_beat(64'(32'h300 + k), 1'b0);
    axis_fifo_read = 1'b1;
    send_beat(64'h313, 1'b1);
    axis_fifo_read = 1'b0;
    chk("pp_cnt", 64'(axis_fifo_cnt), 64'd2);
    chk("pp_head_lo", head_beat(0), 64'h200);
    chk("pp_head_hi", head_beat(19), 64'h213);
    chk("pp_ferr", 64'(frame_err), 64'd0);
    axis_fifo_read = 1'b1;
    tick();
    axis_fifo_read = 1'b0;
    chk("tail_cnt", 64'(axis_fifo_cnt), 64'd1);
    chk("tail_head_lo", head_beat(0), 64'h300);
    chk("tail_head_hi", head_beat(19), 64'h313);
    flush();

    // Short packet
    for (int k = 0; k < 8; k++) send_beat(64'(32'hA0 + k), k == 7);
    chk("short_ferr", 64'(frame_err), 64'd1);
    chk("short_cnt", 64'(axis_fifo_cnt), 64'd0);
    send_word(4, 1'b1);
    chk("after_short_cnt", 64'(axis_fifo_cnt), 64'd1);
    chk("after_short_lo", head_beat(0), 64'h400);
    chk("after_short_mid", head_beat(7), 64'h407);
    chk("after_short_hi", head_beat(19), 64'h413);
    chk("after_short_ferr", 64'(frame_err), 64'd1);
    flush();
    chk("clr_ferr", 64'(frame_err), 64'd0);
    chk("clr_cnt", 64'(axis_fifo_cnt), 64'd0);
    chk("clr_wordcnt", 64'(preload_word_cnt), 64'd0);

    // Reads while empty must not move the read pointer
    axis_fifo_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_read_cnt", 64'(axis_fifo_cnt), 64'd0);
    end
    axis_fifo_read = 1'b0;
    send_word(5, 1'b0);
    chk("empty_read_head", head_beat(0), 64'h500);
    chk("empty_read_head_hi", head_beat(19), 64'h513);

    // Reset in the middle of a word
    for (int k = 0; k < 10; k++) send_beat(64'(32'h600 + k), 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_tready", 64'(s_axis_tready), 64'd0);
    rst = 1'b0;
    chk("midrst_cnt", 64'(axis_fifo_cnt), 64'd0);
    send_word(7, 1'b0);
    chk("midrst_word_cnt", 64'(axis_fifo_cnt), 64'd1);
    chk("midrst_lo", head_beat(0), 64'h700);
    chk("midrst_mid", head_beat(10), 64'h70a);
    chk("midrst_hi", head_beat(19), 64'h713);
    chk("midrst_wordcnt", 64'(preload_word_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
